// File: rtl/number_rom_arbiter_if.sv
// Bus bundle between the score/time display controllers, the shared digit-glyph
// ROM and number_rom_arbiter.
//   slave  : arbiter side (takes requests and ROM data; drives grants, returns,
//            ROM address and busy)
//   master : requester/ROM side (the mirror image)
interface number_rom_arbiter_if #(
  parameter int NUM_BITS   = 4,
  parameter int COUNT_BITS = 8
);
  logic                  score_req;
  logic [NUM_BITS-1:0]   score_number;
  logic [COUNT_BITS-1:0] score_count;
  logic                  score_gnt;
  logic                  score_valid;
  logic                  score_pixel;

  logic                  time_req;
  logic [NUM_BITS-1:0]   time_number;
  logic [COUNT_BITS-1:0] time_count;
  logic                  time_gnt;
  logic                  time_valid;
  logic                  time_pixel;

  logic [NUM_BITS-1:0]   selected_number;
  logic [COUNT_BITS-1:0] number_count;
  logic                  read_enable;
  logic                  number_pixel;
  logic                  busy;

  modport slave (
    input  score_req, score_number, score_count,
    input  time_req, time_number, time_count,
    input  number_pixel,
    output score_gnt, score_valid, score_pixel,
    output time_gnt, time_valid, time_pixel,
    output selected_number, number_count, read_enable, busy
  );

  modport master (
    output score_req, score_number, score_count,
    output time_req, time_number, time_count,
    output number_pixel,
    input  score_gnt, score_valid, score_pixel,
    input  time_gnt, time_valid, time_pixel,
    input  selected_number, number_count, read_enable, busy
  );
endinterface

// File: rtl/number_rom_arbiter.sv
// Round-robin arbiter for the shared digit-glyph ROM, serving the score and
// time display controllers in the clock_25 domain. One transaction at a time:
// grant, issue the latched address, wait out the ROM latency, return the pixel.
// Ports:
//   clock_25    pixel clock
//   reset       asynchronous active-low reset
//   sync_reset  synchronous active-high game restart (discards any transaction)
//   bus         number_rom_arbiter_if.slave: req/gnt/valid/pixel per
//               requester, ROM address/read strobe/data, busy
module number_rom_arbiter #(
  parameter int NUM_BITS    = 4,
  parameter int COUNT_BITS  = 8,
  parameter int ROM_LATENCY = 1   // 1..3
) (
  input logic               clock_25,
  input logic               reset,
  input logic               sync_reset,
  number_rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t                state;
  logic                  owner;      // 0 = score, 1 = time
  logic                  prio_time;  // set after a score grant: time wins the next tie
  logic [1:0]            wait_cnt;
  logic [NUM_BITS-1:0]   lat_number;
  logic [COUNT_BITS-1:0] lat_count;
  logic                  lat_bad;    // digit > 9: skip the ROM, return 0
  logic                  ret_pixel;

  // Score wins if it is the only requester or it holds the tie priority.
  logic pick_score;
  assign pick_score = bus.score_req && (!bus.time_req || !prio_time);

  // Sampled in RETURN, which is ROM_LATENCY cycles after the read strobe.
  assign ret_pixel = lat_bad ? 1'b0 : bus.number_pixel;
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      owner               <= 1'b0;
      prio_time           <= 1'b0;
      wait_cnt            <= '0;
      lat_number          <= '0;
      lat_count           <= '0;
      lat_bad             <= 1'b0;
      bus.score_gnt       <= 1'b0;
      bus.score_valid     <= 1'b0;
      bus.score_pixel     <= 1'b0;
      bus.time_gnt        <= 1'b0;
      bus.time_valid      <= 1'b0;
      bus.time_pixel      <= 1'b0;
      bus.selected_number <= '0;
      bus.number_count    <= '0;
      bus.read_enable     <= 1'b0;
    end else if (sync_reset) begin
      state               <= IDLE;
      owner               <= 1'b0;
      prio_time           <= 1'b0;
      wait_cnt            <= '0;
      lat_number          <= '0;
      lat_count           <= '0;
      lat_bad             <= 1'b0;
      bus.score_gnt       <= 1'b0;
      bus.score_valid     <= 1'b0;
      bus.score_pixel     <= 1'b0;
      bus.time_gnt        <= 1'b0;
      bus.time_valid      <= 1'b0;
      bus.time_pixel      <= 1'b0;
      bus.selected_number <= '0;
      bus.number_count    <= '0;
      bus.read_enable     <= 1'b0;
    end else begin
      bus.score_gnt   <= 1'b0;
      bus.time_gnt    <= 1'b0;
      bus.score_valid <= 1'b0;
      bus.time_valid  <= 1'b0;
      bus.read_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_score) begin
            bus.score_gnt <= 1'b1;
            owner         <= 1'b0;
            prio_time     <= 1'b1;
            lat_number    <= bus.score_number;
            lat_count     <= bus.score_count;
            lat_bad       <= (bus.score_number > NUM_BITS'(9));
            state         <= ISSUE;
          end else if (bus.time_req) begin
            bus.time_gnt  <= 1'b1;
            owner         <= 1'b1;
            prio_time     <= 1'b0;
            lat_number    <= bus.time_number;
            lat_count     <= bus.time_count;
            lat_bad       <= (bus.time_number > NUM_BITS'(9));
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.selected_number <= lat_number;
          bus.number_count    <= lat_count;
          bus.read_enable     <= !lat_bad;
          wait_cnt            <= 2'(ROM_LATENCY - 1);
          state               <= WAIT;
        end
        WAIT: begin
          // Address held for the whole wait; the ROM has registered it by now.
          if (wait_cnt == 2'd0) begin
            bus.selected_number <= '0;
            bus.number_count    <= '0;
            state               <= RETURN;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RETURN: begin
          if (owner) begin
            bus.time_valid  <= 1'b1;
            bus.time_pixel  <= ret_pixel;
          end else begin
            bus.score_valid <= 1'b1;
            bus.score_pixel <= ret_pixel;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_number_rom_arbiter.sv
module tb_number_rom_arbiter;

  logic clock_25 = 1'b0;
  logic reset;
  logic sync1, sync3;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #20 clock_25 = ~clock_25;

  number_rom_arbiter_if #(.NUM_BITS(4), .COUNT_BITS(8)) if1 ();
  number_rom_arbiter_if #(.NUM_BITS(4), .COUNT_BITS(8)) if3 ();

  number_rom_arbiter #(.ROM_LATENCY(1)) u1 (
    .clock_25(clock_25), .reset(reset), .sync_reset(sync1), .bus(if1.slave));
  number_rom_arbiter #(.ROM_LATENCY(3)) u3 (
    .clock_25(clock_25), .reset(reset), .sync_reset(sync3), .bus(if3.slave));

  // ROM contents: digit 0 is blank, otherwise bit = number[0] ^ count[1].
  function automatic logic rom_bit(input logic [3:0] n, input logic [7:0] c);
    return (n != 4'd0) && (n[0] ^ c[1]);
  endfunction

  // ROM models: registered address, ROM_LATENCY register stages.
  logic r1 = 1'b0, r3a = 1'b0, r3b = 1'b0, r3c = 1'b0;
  always @(posedge clock_25) begin
    r1  <= rom_bit(if1.selected_number, if1.number_count);
    r3a <= rom_bit(if3.selected_number, if3.number_count);
    r3b <= r3a;
    r3c <= r3b;
  end
  assign if1.number_pixel = r1;
  assign if3.number_pixel = r3c;

  typedef struct packed { logic owner; logic pix; } exp_t;  // owner 1 = time
  exp_t q1[$];
  exp_t q3[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Scoreboard side: every valid strobe pops one expected return.
  task automatic mon();
    exp_t e;
    if (if1.score_gnt || if1.time_gnt)
      chk("gnt_overlap1", {31'd0, if1.score_gnt & if1.time_gnt}, 32'd0);
    if (if1.score_valid || if1.time_valid) begin
      chk("valid_overlap1", {31'd0, if1.score_valid & if1.time_valid}, 32'd0);
      chk("valid_expected1", {31'd0, q1.size() > 0}, 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("owner1", {31'd0, if1.time_valid}, {31'd0, e.owner});
        chk("pixel1", {31'd0, if1.time_valid ? if1.time_pixel : if1.score_pixel},
            {31'd0, e.pix});
      end
    end
    if (if3.score_valid || if3.time_valid) begin
      chk("valid_overlap3", {31'd0, if3.score_valid & if3.time_valid}, 32'd0);
      chk("valid_expected3", {31'd0, q3.size() > 0}, 32'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("owner3", {31'd0, if3.time_valid}, {31'd0, e.owner});
        chk("pixel3", {31'd0, if3.time_valid ? if3.time_pixel : if3.score_pixel},
            {31'd0, e.pix});
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_25);
    @(negedge clock_25);
    cyc++;
    mon();
  endtask

  initial begin
    int   n;
    logic exp_order [3];
    reset = 1'b0; sync1 = 1'b0; sync3 = 1'b0;
    if1.score_req = 0; if1.score_number = 0; if1.score_count = 0;
    if1.time_req  = 0; if1.time_number  = 0; if1.time_count  = 0;
    if3.score_req = 0; if3.score_number = 0; if3.score_count = 0;
    if3.time_req  = 0; if3.time_number  = 0; if3.time_count  = 0;
    repeat (2) tick();

    // Reset state
    chk("rst_gnt",   {30'd0, if1.score_gnt, if1.time_gnt}, 32'd0);
    chk("rst_valid", {30'd0, if1.score_valid, if1.time_valid}, 32'd0);
    chk("rst_pix",   {30'd0, if1.score_pixel, if1.time_pixel}, 32'd0);
    chk("rst_rd",    {31'd0, if1.read_enable}, 32'd0);
    chk("rst_busy",  {31'd0, if1.busy}, 32'd0);
    chk("rst_addr",  {20'd0, if1.selected_number, if1.number_count}, 32'd0);

    // Single score read, latency 1
    reset = 1'b1; cyc = 0;
    if1.score_req = 1; if1.score_number = 4'd3; if1.score_count = 8'd17;
    q1.push_back('{owner: 1'b0, pix: 1'b1});
    tick();
    chk("t1_gnt", {30'd0, if1.score_gnt, if1.time_gnt}, 32'd2);
    chk("t1_busy", {31'd0, if1.busy}, 32'd1);
    if1.score_req = 0; if1.score_number = 4'd0; if1.score_count = 8'd0;
    tick();
    chk("t1_rd", {31'd0, if1.read_enable}, 32'd1);
    chk("t1_sel", {28'd0, if1.selected_number}, 32'd3);
    chk("t1_cnt", {24'd0, if1.number_count}, 32'd17);
    tick();
    chk("t1_early_valid", {30'd0, if1.score_valid, if1.read_enable}, 32'd0);
    tick();
    chk("t1_valid", {30'd0, if1.score_valid, if1.score_pixel}, 32'd3);
    chk("t1_time_quiet", {29'd0, if1.time_gnt, if1.time_valid, if1.time_pixel}, 32'd0);
    chk("t1_idle", {31'd0, if1.busy}, 32'd0);

    // Both requesting from reset: score, time, score
    reset = 1'b0; tick(); reset = 1'b1;
    if1.score_req = 1; if1.score_number = 4'd5; if1.score_count = 8'd0;
    if1.time_req  = 1; if1.time_number  = 4'd6; if1.time_count  = 8'd2;
    q1.push_back('{owner: 1'b0, pix: 1'b1});
    q1.push_back('{owner: 1'b1, pix: 1'b1});
    q1.push_back('{owner: 1'b0, pix: 1'b1});
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      do begin tick(); n++; end while (!(if1.score_gnt || if1.time_gnt) && n < 20);
      chk("t2_gnt_seen", {31'd0, if1.score_gnt || if1.time_gnt}, 32'd1);
      chk("t2_order", {31'd0, if1.time_gnt}, {31'd0, exp_order[g]});
    end
    if1.score_req = 0; if1.time_req = 0;
    repeat (6) tick();
    chk("t2_drained", q1.size(), 32'd0);

    // Invalid digit from time: no ROM read, pixel forced 0
    cyc = 0;
    if1.time_req = 1; if1.time_number = 4'd12; if1.time_count = 8'd2;
    q1.push_back('{owner: 1'b1, pix: 1'b0});
    tick();
    chk("t3_gnt", {30'd0, if1.score_gnt, if1.time_gnt}, 32'd1);
    if1.time_req = 0;
    tick();
    chk("t3_no_rd_a", {31'd0, if1.read_enable}, 32'd0);
    tick();
    chk("t3_no_rd_b", {31'd0, if1.read_enable}, 32'd0);
    tick();
    chk("t3_valid", {30'd0, if1.time_valid, if1.time_pixel}, 32'd2);

    // ROM latency 3 on the second instance
    cyc = 0;
    if3.score_req = 1; if3.score_number = 4'd3; if3.score_count = 8'd17;
    q3.push_back('{owner: 1'b0, pix: 1'b1});
    tick();
    chk("t4_gnt", {31'd0, if3.score_gnt}, 32'd1);
    if3.score_req = 0; if3.score_number = 4'd0; if3.score_count = 8'd0;
    tick();
    chk("t4_rd", {31'd0, if3.read_enable}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_addr_stable", {20'd0, if3.selected_number, if3.number_count},
          {20'd0, 4'd3, 8'd17});
      tick();
    end
    chk("t4_not_yet", {31'd0, if3.score_valid}, 32'd0);
    tick();
    chk("t4_valid", {30'd0, if3.score_valid, if3.score_pixel}, 32'd3);

    // sync_reset on instance 3 (tie priority now with time): score wins again,
    // and requests present during sync_reset are not granted that cycle
    tick();
    cyc = 0;
    sync3 = 1'b1;
    if3.score_req = 1; if3.score_number = 4'd3; if3.score_count = 8'd17;
    if3.time_req  = 1; if3.time_number  = 4'd6; if3.time_count  = 8'd2;
    tick();
    chk("t5b_sync_nognt", {30'd0, if3.score_gnt, if3.time_gnt}, 32'd0);
    sync3 = 1'b0;
    q3.push_back('{owner: 1'b0, pix: 1'b1});
    tick();
    chk("t5b_first_score", {30'd0, if3.score_gnt, if3.time_gnt}, 32'd2);
    if3.score_req = 0; if3.time_req = 0;
    repeat (7) tick();
    chk("t5b_drained", q3.size(), 32'd0);

    // sync_reset during WAIT of a time transaction on instance 1
    cyc = 0;
    if1.time_req = 1; if1.time_number = 4'd6; if1.time_count = 8'd2;
    tick();
    chk("t5_gnt", {31'd0, if1.time_gnt}, 32'd1);
    if1.time_req = 0;
    tick();
    chk("t5_in_wait", {31'd0, if1.read_enable}, 32'd1);
    sync1 = 1'b1;
    tick();
    sync1 = 1'b0;
    chk("t5_busy", {31'd0, if1.busy}, 32'd0);
    chk("t5_cleared", {28'd0, if1.time_valid, if1.read_enable, if1.score_pixel,
        if1.time_pixel}, 32'd0);
    repeat (4) tick();
    if1.score_req = 1; if1.score_number = 4'd5; if1.score_count = 8'd0;
    if1.time_req  = 1;
    tick();
    chk("t5_first_score", {30'd0, if1.score_gnt, if1.time_gnt}, 32'd2);
    q1.push_back('{owner: 1'b0, pix: 1'b1});
    if1.score_req = 0; if1.time_req = 0;
    repeat (5) tick();
    chk("t5_drained", q1.size(), 32'd0);

    // Async reset during ISSUE
    cyc = 0;
    if1.score_req = 1;
    tick();
    chk("t6_gnt", {31'd0, if1.score_gnt}, 32'd1);
    if1.score_req = 0;
    reset = 1'b0;
    #1;
    chk("t6_async_u1", {27'd0, if1.busy, if1.score_gnt, if1.score_pixel,
        if1.read_enable, if1.score_valid}, 32'd0);
    chk("t6_async_u3", {31'd0, if3.score_pixel}, 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_idle", {30'd0, if1.busy, if1.read_enable}, 32'd0);
    end
    chk("final_q1", q1.size(), 32'd0);
    chk("final_q3", q3.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
